// File: rtl/load_hash_if.sv
// Bundles the load request, memory read port and assembled-hash outputs of load_hash.
// The master side drives enable and h_rdata; the slave side (load_hash) drives the rest.
interface load_hash_if #(
  parameter int HASH_LENGTH = 8
);
  localparam int ADDR_WIDTH = $clog2(HASH_LENGTH);

  logic                  enable;
  logic [31:0]           h_rdata;
  logic                  h_read;
  logic [ADDR_WIDTH-1:0] h_address;
  logic [255:0]          hash_vector;
  logic                  h_vector_complete;

  modport master (
    output enable,
    output h_rdata,
    input  h_read,
    input  h_address,
    input  hash_vector,
    input  h_vector_complete
  );

  modport slave (
    input  enable,
    input  h_rdata,
    output h_read,
    output h_address,
    output hash_vector,
    output h_vector_complete
  );
endinterface

// File: rtl/load_hash.sv
// Reads HASH_LENGTH 32-bit words from a one-cycle-latency memory and assembles them into a 256-bit hash.
// Optional build macro HASH_BYTE_SWAP_EN byte-reverses each captured word.
module load_hash #(
  parameter int HASH_LENGTH = 8
) (
  input logic       clock,
  input logic       reset,
  load_hash_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(HASH_LENGTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(HASH_LENGTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                state, state_next;
  logic                  h_read_q, h_read_next;
  logic [ADDR_WIDTH-1:0] h_address_q, h_address_next;
  logic                  complete_q, complete_next;
  logic [255:0]          hash_vector_q;
  logic                  rd_pending;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [31:0]           captured_word;

  always_comb begin
`ifdef HASH_BYTE_SWAP_EN
    captured_word = {bus.h_rdata[7:0], bus.h_rdata[15:8], bus.h_rdata[23:16], bus.h_rdata[31:24]};
`else
    captured_word = bus.h_rdata;
`endif
  end

  // Dropping enable anywhere lands in IDLE because the defaults below describe IDLE.
  always_comb begin
    state_next     = IDLE;
    h_read_next    = 1'b0;
    h_address_next = '0;
    complete_next  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable) begin
          state_next  = READ;
          h_read_next = 1'b1;
        end
      end
      READ: begin
        if (bus.enable) begin
          if (h_address_q == LAST_ADDR) begin
            state_next = DRAIN;
          end else begin
            state_next     = READ;
            h_read_next    = 1'b1;
            h_address_next = h_address_q + 1'b1;
          end
        end
      end
      DRAIN, DONE: begin
        if (bus.enable) begin
          state_next    = DONE;
          complete_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      h_read_q    <= 1'b0;
      h_address_q <= '0;
      complete_q  <= 1'b0;
    end else begin
      state       <= state_next;
      h_read_q    <= h_read_next;
      h_address_q <= h_address_next;
      complete_q  <= complete_next;
    end
  end

  // A read whose address cycle saw enable low is never captured, so an abort stops further writes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_pending    <= 1'b0;
      rd_addr       <= '0;
      hash_vector_q <= '0;
    end else begin
      rd_pending <= h_read_q && bus.enable;
      rd_addr    <= h_address_q;
      for (int k = 0; k < HASH_LENGTH; k++) begin
        if (rd_pending && (rd_addr == ADDR_WIDTH'(k))) begin
          hash_vector_q[k*32 +: 32] <= captured_word;
        end
      end
    end
  end

  assign bus.h_read            = h_read_q;
  assign bus.h_address         = h_address_q;
  assign bus.h_vector_complete = complete_q;
  assign bus.hash_vector       = hash_vector_q;
endmodule

// File: tb/tb_load_hash.sv
// Randomized directed bench for load_hash: a behavioural memory plus a slice-level model of the hash vector.
// Edge numbering inside a load counts the edge that samples enable as edge 1.
module tb_load_hash;
  logic clock;
  logic reset;

  load_hash_if #(.HASH_LENGTH(8)) bus ();

  load_hash #(.HASH_LENGTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0]  mem [8];
  logic [255:0] exp_vec;
  logic [255:0] saved_vec;
  logic         lat_read;
  logic [2:0]   lat_addr;
  int           check_count = 0;
  int           pass_count  = 0;
  int           fail_count  = 0;
  int           read_count  = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory answers one cycle after the address is presented.
  always @(negedge clock) begin
    lat_read = bus.h_read;
    lat_addr = bus.h_address;
  end

  always @(posedge clock) begin
    #1;
    bus.h_rdata = (lat_read === 1'b1) ? mem[lat_addr] : $urandom();
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] stored_word(input logic [31:0] w);
`ifdef HASH_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic model_load(input int count);
    for (int k = 0; k < count; k++) exp_vec[k*32 +: 32] = stored_word(mem[k]);
  endtask

  task automatic check_output(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    if (bus.h_read === 1'b1) read_count++;
  endtask

  task automatic apply_stimulus(input logic en);
    bus.enable = en;
  endtask

  task automatic randomize_mem();
    for (int k = 0; k < 8; k++) mem[k] = $urandom();
  endtask

  // Follows a load from edge start_n through the edge that raises complete.
  task automatic watch_load(input string tag, input int start_n);
    for (int n = start_n; n <= 10; n++) begin
      tick();
      check_output({tag, "_read"}, 256'(bus.h_read), 256'(n <= 8));
      if (n <= 8) check_output({tag, "_addr"}, 256'(bus.h_address), 256'(n - 1));
      check_output({tag, "_complete"}, 256'(bus.h_vector_complete), 256'(n == 10));
    end
  endtask

  initial begin
    $display("[TB] load_hash bench starting");
    reset       = 1'b0;
    bus.enable  = 1'b0;
    bus.h_rdata = '0;
    exp_vec     = '0;
    for (int k = 0; k < 8; k++) mem[k] = 32'h1000_0000 + 32'(k);
    #1;
    check_output("rst_read", 256'(bus.h_read), 256'(0));
    check_output("rst_addr", 256'(bus.h_address), 256'(0));
    check_output("rst_complete", 256'(bus.h_vector_complete), 256'(0));
    check_output("rst_vector", bus.hash_vector, exp_vec);
    @(negedge clock);
    reset = 1'b1;
    tick();
    check_output("idle_read", 256'(bus.h_read), 256'(0));

    // Basic load of the counting pattern.
    read_count = 0;
    apply_stimulus(1'b1);
    watch_load("load1", 1);
    model_load(8);
    check_output("load1_vector", bus.hash_vector, exp_vec);
    check_output("load1_slice0", 256'(bus.hash_vector[31:0]), 256'(stored_word(32'h1000_0000)));
    check_output("load1_slice7", 256'(bus.hash_vector[255:224]), 256'(stored_word(32'h1000_0007)));

    // Holding enable after DONE must not start a second load.
    for (int c = 0; c < 20; c++) begin
      tick();
      check_output("hold_complete", 256'(bus.h_vector_complete), 256'(1));
    end
    check_output("hold_reads", 256'(read_count), 256'(8));
    check_output("hold_vector", bus.hash_vector, exp_vec);

    // Leaving DONE clears the flag but keeps the vector.
    apply_stimulus(1'b0);
    tick();
    check_output("exit_complete", 256'(bus.h_vector_complete), 256'(0));
    check_output("exit_read", 256'(bus.h_read), 256'(0));
    check_output("exit_vector", bus.hash_vector, exp_vec);

    // Abort while address 4 is presented, then a one-cycle gap and a fresh load.
    randomize_mem();
    apply_stimulus(1'b1);
    for (int n = 1; n <= 5; n++) tick();
    check_output("abort_addr", 256'(bus.h_address), 256'(4));
    apply_stimulus(1'b0);
    tick();
    check_output("abort_read", 256'(bus.h_read), 256'(0));
    check_output("abort_addr0", 256'(bus.h_address), 256'(0));
    check_output("abort_complete", 256'(bus.h_vector_complete), 256'(0));
    model_load(4);
    check_output("abort_vector", bus.hash_vector, exp_vec);
    apply_stimulus(1'b1);
    tick();
    check_output("reload_read", 256'(bus.h_read), 256'(1));
    check_output("reload_addr", 256'(bus.h_address), 256'(0));
    check_output("reload_vector", bus.hash_vector, exp_vec);
    watch_load("reload", 2);
    model_load(8);
    check_output("reload_full", bus.hash_vector, exp_vec);

    // Reset asserted in DRAIN clears everything without a clock edge.
    apply_stimulus(1'b0);
    tick();
    randomize_mem();
    mem[0] = 32'h0011_2233;
    saved_vec = bus.hash_vector;
    apply_stimulus(1'b1);
    for (int n = 1; n <= 9; n++) tick();
    check_output("drain_read", 256'(bus.h_read), 256'(0));
    check_output("drain_complete", 256'(bus.h_vector_complete), 256'(0));
    reset = 1'b0;
    #1;
    exp_vec = '0;
    check_output("async_read", 256'(bus.h_read), 256'(0));
    check_output("async_addr", 256'(bus.h_address), 256'(0));
    check_output("async_complete", 256'(bus.h_vector_complete), 256'(0));
    check_output("async_vector", bus.hash_vector, exp_vec);
    @(negedge clock);
    reset = 1'b1;
    watch_load("postrst", 1);
    model_load(8);
    check_output("postrst_vector", bus.hash_vector, exp_vec);
`ifdef HASH_BYTE_SWAP_EN
    check_output("swap_slice0", 256'(bus.hash_vector[31:0]), 256'(32'h3322_1100));
`else
    check_output("swap_slice0", 256'(bus.hash_vector[31:0]), 256'(32'h0011_2233));
`endif
    if (saved_vec === exp_vec) $display("[TB] note: random data repeated previous vector");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
